regfile_wr_queue: RTL and testbench

//  Write-side front end for the 1R1W register file. Accepts write requests over a

---
 rtl/regfile_pkg.sv | 19 +
 rtl/wrq_fifo.sv | 79 +++++++
 rtl/regfile_wr_queue.sv | 124 ++++++++++++
 tb/tb_regfile_wr_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-queue front end.
package regfile_pkg;

    localparam int RF_ADDR_W      = 7;
    localparam int RF_DATA_W      = 13;
    localparam int RF_NUM_ENTRIES = 16;
    localparam int RF_DEPTH       = 4;

    typedef enum logic [0:0] {
        WRQ_INIT = 1'b0,
        WRQ_RUN  = 1'b1
    } wrq_state_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wrq_fifo.sv
// In-order write-request queue; exposes every slot plus an occupancy mask
// so the parent can search pending writes for forwarding.
module wrq_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH = RF_DEPTH,
    parameter type T     = wr_req_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  T                 i_din,
    input  logic             i_pop,
    output T                 o_head,
    output T [DEPTH-1:0]     o_entries,
    output logic [DEPTH-1:0] o_valid,
    output logic [PW-1:0]    o_tail,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    T [DEPTH-1:0]  r_mem;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_off;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        o_valid = '0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PW'(i) - r_head;
            o_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

    assign o_head    = r_mem[r_head];
    assign o_entries = r_mem;
    assign o_tail    = r_tail;
    assign o_count   = r_count;

endmodule

// File: rtl/regfile_wr_queue.sv
// Write-side front end of the 1R1W register file: post-reset clear sweep,
// queued writes drained one per cycle, and youngest-match read forwarding.
//
//   state    | meaning
//   WRQ_INIT | sweeping zeros into entries 0..NUM_ENTRIES-1, no traffic accepted
//   WRQ_RUN  | accepting requests, draining the queue to the regfile port
module regfile_wr_queue
    import regfile_pkg::*;
#(
    parameter int  ADDR_W      = RF_ADDR_W,
    parameter int  DATA_W      = RF_DATA_W,
    parameter int  NUM_ENTRIES = RF_NUM_ENTRIES,
    parameter int  DEPTH       = RF_DEPTH,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rf_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              init_busy,
    output logic [CW-1:0]     count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    wrq_state_e        r_state;
    logic [ADDR_W-1:0] r_init_cnt;

    req_t              w_din;
    req_t              w_head;
    req_t [DEPTH-1:0]  w_entries;
    logic [DEPTH-1:0]  w_valid;
    logic [PW-1:0]     w_tail;
    logic [PW-1:0]     w_idx;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign wr_ready  = (r_state == WRQ_RUN) && !w_full;
    assign w_push    = wr_valid && wr_ready;
    assign w_din     = '{addr: wr_addr, data: wr_data};
    assign w_pop     = (r_state == WRQ_RUN) && rf_we;
    assign init_busy = (r_state == WRQ_INIT);

    wrq_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_din     (w_din),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_tail    (w_tail),
        .o_count   (count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // No regfile writes at all while reset is held, even though the state reads INIT.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (rst_n) begin
            if (r_state == WRQ_INIT) begin
                rf_we    = !rf_stall;
                rf_waddr = r_init_cnt;
            end else begin
                rf_we    = !w_empty && !rf_stall;
                rf_waddr = w_head.addr;
                rf_wdata = w_head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WRQ_INIT;
            r_init_cnt <= '0;
        end else if (r_state == WRQ_INIT && rf_we) begin
            if (r_init_cnt == ADDR_W'(NUM_ENTRIES - 1)) begin
                r_state    <= WRQ_RUN;
                r_init_cnt <= '0;
            end else begin
                r_init_cnt <= r_init_cnt + ADDR_W'(1);
            end
        end
    end

    // Walk oldest to youngest so the last match (tail-1 side) wins the priority.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        w_idx    = '0;
        if (r_state == WRQ_RUN) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                w_idx = w_tail - PW'(k + 1);
                if (w_valid[w_idx] && (w_entries[w_idx].addr == fwd_addr)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = w_entries[w_idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_queue.sv
// Scoreboard bench for regfile_wr_queue: accepted writes go into an expected
// queue, a negedge monitor checks every regfile write and forwarding result.
module tb_regfile_wr_queue;

    localparam int AW = 7;
    localparam int DW = 13;
    localparam int NE = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rf_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          init_busy;
    logic [2:0]    count;

    always #5 clk = ~clk;

    regfile_wr_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .init_busy (init_busy),
        .count     (count)
    );

    typedef struct {
        int addr;
        int data;
    } ent_t;

    ent_t exp_q[$];
    int   m_init_cnt = 0;
    int   n_checks   = 0;
    int   n_errors   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: record the write as accepted at the edge that commits it.
    task automatic cyc();
        logic          acc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        acc = wr_valid && wr_ready && rst_n;
        a   = wr_addr;
        d   = wr_data;
        @(posedge clk);
        if (acc) exp_q.push_back('{addr: int'(a), data: int'(d)});
        #1;
    endtask

    task automatic push(input int a, input int d);
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_data  = DW'(d);
        cyc();
        wr_valid = 1'b0;
    endtask

    // Monitor: reference behaviour from the queue model, checked every cycle.
    initial begin
        bit e_hit;
        int e_data;
        bit e_we;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_we", rf_we, 0);
                chk("rst_count", count, 0);
                chk("rst_busy", init_busy, 1);
                chk("rst_ready", wr_ready, 0);
                chk("rst_hit", fwd_hit, 0);
                exp_q.delete();
                m_init_cnt = 0;
            end else if (m_init_cnt < NE) begin
                chk("init_busy", init_busy, 1);
                chk("init_ready", wr_ready, 0);
                chk("init_hit", fwd_hit, 0);
                chk("init_we", rf_we, !rf_stall);
                if (!rf_stall) begin
                    chk("init_waddr", rf_waddr, m_init_cnt);
                    chk("init_wdata", rf_wdata, 0);
                    m_init_cnt++;
                end
            end else begin
                chk("run_busy", init_busy, 0);
                chk("run_count", count, exp_q.size());
                chk("run_ready", wr_ready, exp_q.size() < D);
                e_hit  = 0;
                e_data = 0;
                for (int i = exp_q.size() - 1; i >= 0; i--) begin
                    if (exp_q[i].addr == int'(fwd_addr)) begin
                        e_hit  = 1;
                        e_data = exp_q[i].data;
                        break;
                    end
                end
                chk("fwd_hit", fwd_hit, e_hit);
                chk("fwd_data", fwd_data, e_data);
                e_we = (exp_q.size() > 0) && !rf_stall;
                chk("run_we", rf_we, e_we);
                if (rf_we && exp_q.size() > 0) begin
                    chk("run_waddr", rf_waddr, exp_q[0].addr);
                    chk("run_wdata", rf_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int a;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rf_stall = 1'b0;
        fwd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain init sweep
        cycles = 0;
        while (init_busy && cycles < 100) begin
            cyc();
            cycles++;
        end
        chk("t1_init_len", cycles, 16);
        chk("t1_ready", wr_ready, 1);

        // Stalled queue fill and youngest-match forwarding
        rf_stall = 1'b1;
        push(5, 'h111);
        push(9, 'h0AA);
        push(5, 'h1FF);
        push(2, 'h003);
        chk("t3_count", count, 4);
        chk("t3_ready", wr_ready, 0);
        fwd_addr = 7'd5;
        #1;
        chk("t3_hit5", fwd_hit, 1);
        chk("t3_data5", fwd_data, 'h1FF);
        fwd_addr = 7'd7;
        #1;
        chk("t3_hit7", fwd_hit, 0);
        rf_stall = 1'b0;
        repeat (4) cyc();
        chk("t3_drained", count, 0);

        // Single write latency
        push(3, 'h1234);
        fwd_addr = 7'd3;
        #1;
        chk("t4_we", rf_we, 1);
        chk("t4_waddr", rf_waddr, 3);
        chk("t4_wdata", rf_wdata, 'h1234);
        chk("t4_hit", fwd_hit, 1);
        chk("t4_fdata", fwd_data, 'h1234);
        cyc();
        chk("t4_hit_n2", fwd_hit, 0);

        // Full queue refuses a push while popping, then streams
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++) push($urandom_range(0, 15), $urandom_range(0, 8191));
        rf_stall = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = AW'($urandom_range(0, 15));
        wr_data  = DW'($urandom_range(0, 8191));
        #1;
        chk("t5_full_ready", wr_ready, 0);
        cyc();
        chk("t5_count3", count, 3);
        for (int i = 0; i < 12; i++) begin
            chk("t5_stream_ready", wr_ready, 1);
            cyc();
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = DW'($urandom_range(0, 8191));
        end
        wr_valid = 1'b0;
        repeat (6) cyc();
        chk("t5_drained", count, 0);

        // Reset mid-drain, then init restart with stalls on cycles 3-5
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++) push($urandom_range(0, 15), $urandom_range(0, 8191));
        rf_stall = 1'b0;
        cyc();
        chk("t6_count3", count, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", rf_we, 0);
        chk("t6_rst_count", count, 0);
        cyc();
        rst_n  = 1'b1;
        cycles = 0;
        while (init_busy && cycles < 100) begin
            rf_stall = (cycles >= 3 && cycles <= 5);
            cyc();
            cycles++;
        end
        rf_stall = 1'b0;
        chk("t2_init_len", cycles, 19);

        // Randomised traffic, including out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            a        = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 127) : $urandom_range(0, 15);
            wr_addr  = AW'(a);
            wr_data  = DW'($urandom_range(0, 8191));
            rf_stall = ($urandom_range(0, 3) == 0);
            fwd_addr = AW'($urandom_range(0, 15));
            cyc();
        end
        wr_valid = 1'b0;
        rf_stall = 1'b0;
        repeat (8) cyc();
        chk("final_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
